// File: rtl/exc_ctrl.sv
// Precise-exception sequencer: flushes and drains the pipe on an exception, redirects fetch
// to the handler, restores fetch to the saved EPC on RTI, and latches a sticky double fault.
module exc_ctrl #(
  parameter int                ADDR_W       = 16,
  parameter logic [ADDR_W-1:0] HANDLER_ADDR = 'h0002,
  parameter int                DRAIN_CYCLES = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic              id_invalidOp,
  input  logic              id_siic,
  input  logic              id_rti,
  input  logic [ADDR_W-1:0] id_pc,
  input  logic [ADDR_W-1:0] id_pc_inc,
  output logic              exc_flush,
  output logic              exc_stall,
  output logic              exc_redirect,
  output logic [ADDR_W-1:0] exc_target,
  output logic [ADDR_W-1:0] epc,
  output logic [1:0]        exc_cause,
  output logic              in_handler,
  output logic              err
);

  typedef enum logic [2:0] {
    S_IDLE, S_DRAIN, S_REDIRECT, S_HANDLER, S_RETURN, S_FAULT
  } state_t;

  localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES - 1);

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] epc_q, epc_d;
  logic [1:0]        cause_q, cause_d;
  logic              inh_q, inh_d;
  logic              err_q, err_d;
  logic              idle_trig;
  logic              hdl_fault;
  logic              hdl_rti;

  // Reset also masks the same-cycle trigger so no flush/stall leaks out during reset.
  assign idle_trig = ~rst & id_valid & (id_invalidOp | id_siic | id_rti);
  assign hdl_fault = id_valid & (id_invalidOp | id_siic);
  assign hdl_rti   = id_valid & id_rti;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    epc_d        = epc_q;
    cause_d      = cause_q;
    inh_d        = inh_q;
    err_d        = err_q;
    exc_flush    = 1'b0;
    exc_stall    = 1'b0;
    exc_redirect = 1'b0;
    exc_target   = HANDLER_ADDR;

    case (state_q)
      S_IDLE: begin
        if (idle_trig) begin
          exc_flush = 1'b1;
          exc_stall = 1'b1;
          cnt_d     = DRAIN_LOAD;
          state_d   = S_DRAIN;
          if (id_invalidOp) begin
            epc_d   = id_pc;
            cause_d = 2'b01;
          end else if (id_siic) begin
            epc_d   = id_pc_inc;
            cause_d = 2'b10;
          end else begin
            epc_d   = id_pc;
            cause_d = 2'b11;
          end
        end
      end
      S_DRAIN: begin
        exc_flush = 1'b1;
        exc_stall = 1'b1;
        if (cnt_q == 4'd0) state_d = S_REDIRECT;
        else               cnt_d   = cnt_q - 4'd1;
      end
      S_REDIRECT: begin
        exc_flush    = 1'b1;
        exc_redirect = 1'b1;
        inh_d        = 1'b1;
        state_d      = S_HANDLER;
      end
      S_HANDLER: begin
        // A new exception inside the handler wins over a coincident RTI.
        if (hdl_fault) begin
          exc_flush = 1'b1;
          exc_stall = 1'b1;
          err_d     = 1'b1;
          state_d   = S_FAULT;
        end else if (hdl_rti) begin
          exc_flush = 1'b1;
          state_d   = S_RETURN;
        end
      end
      S_RETURN: begin
        exc_flush    = 1'b1;
        exc_redirect = 1'b1;
        exc_target   = epc_q;
        inh_d        = 1'b0;
        cause_d      = 2'b00;
        state_d      = S_IDLE;
      end
      S_FAULT: begin
        exc_flush = 1'b1;
        exc_stall = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      epc_q   <= '0;
      cause_q <= 2'b00;
      inh_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      epc_q   <= epc_d;
      cause_q <= cause_d;
      inh_q   <= inh_d;
      err_q   <= err_d;
    end
  end

  assign epc        = epc_q;
  assign exc_cause  = cause_q;
  assign in_handler = inh_q;
  assign err        = err_q;

endmodule

// File: tb/tb_exc_ctrl.sv
// Bench for exc_ctrl: directed scenarios followed by random decode traffic, all checked
// against a timestamp-based model of the exception timeline.
module tb_exc_ctrl;
  localparam int          D     = 3;
  localparam logic [15:0] HADDR = 16'h0002;

  logic        clk = 1'b0;
  logic        rst, id_valid, id_invalidOp, id_siic, id_rti;
  logic [15:0] id_pc, id_pc_inc;
  logic        exc_flush, exc_stall, exc_redirect, in_handler, err;
  logic [15:0] exc_target, epc;
  logic [1:0]  exc_cause;

  always #5 clk = ~clk;

  exc_ctrl #(.ADDR_W(16), .HANDLER_ADDR(HADDR), .DRAIN_CYCLES(D)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_invalidOp(id_invalidOp),
    .id_siic(id_siic), .id_rti(id_rti), .id_pc(id_pc), .id_pc_inc(id_pc_inc),
    .exc_flush(exc_flush), .exc_stall(exc_stall), .exc_redirect(exc_redirect),
    .exc_target(exc_target), .epc(epc), .exc_cause(exc_cause),
    .in_handler(in_handler), .err(err)
  );

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit chk_en   = 0;

  // Model: exception timeline as timestamps (trigger cycle, RTI cycle) plus fault flag.
  bit          m_active = 0, m_fault = 0, m_err = 0;
  int          m_t0 = 0, m_rti_t = -1;
  logic [15:0] m_epc = 16'h0;
  logic [1:0]  m_cause = 2'b00;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step(input bit v, input bit inv, input bit siic, input bit rti,
                      input bit r, input logic [15:0] pc);
    bit idle, drain, redir, hand, ret, itrig, hflt, hrti;
    int k;
    rst = r; id_valid = v; id_invalidOp = inv; id_siic = siic; id_rti = rti;
    id_pc = pc; id_pc_inc = pc + 16'd2;
    k     = cyc - m_t0;
    idle  = !m_fault && !m_active;
    drain = m_active && k >= 1 && k <= D;
    redir = m_active && k == D + 1;
    hand  = m_active && k >= D + 2 && m_rti_t < 0;
    ret   = m_active && m_rti_t >= 0 && cyc == m_rti_t + 1;
    itrig = idle && !r && v && (inv || siic || rti);
    hflt  = hand && v && (inv || siic);
    hrti  = hand && v && rti && !hflt;
    #4;
    if (chk_en) begin
      chk("flush", exc_flush, m_fault || drain || redir || ret || itrig || hflt || hrti);
      chk("stall", exc_stall, m_fault || drain || itrig || hflt);
      chk("redirect", exc_redirect, redir || ret);
      chk("target", exc_target, ret ? m_epc : HADDR);
      chk("epc", epc, m_epc);
      chk("cause", exc_cause, m_cause);
      chk("err", err, m_err);
      if (!m_fault) chk("in_handler", in_handler, m_active && k >= D + 2);
    end
    @(posedge clk);
    if (r) begin
      m_active = 0; m_fault = 0; m_err = 0; m_epc = 16'h0; m_cause = 2'b00; m_rti_t = -1;
    end else if (itrig) begin
      m_active = 1; m_t0 = cyc; m_rti_t = -1;
      if (inv)       begin m_epc = pc;         m_cause = 2'b01; end
      else if (siic) begin m_epc = pc + 16'd2; m_cause = 2'b10; end
      else           begin m_epc = pc;         m_cause = 2'b11; end
    end else if (hflt) begin
      m_fault = 1; m_err = 1; m_active = 0;
    end else if (hrti) begin
      m_rti_t = cyc;
    end else if (ret) begin
      m_active = 0; m_cause = 2'b00;
    end
    cyc++;
    #1;
    $display("cyc %0d rst=%0b v=%0b inv=%0b siic=%0b rti=%0b pc=%h | flush=%0b stall=%0b redir=%0b tgt=%h epc=%h cause=%0d inh=%0b err=%0b",
             cyc, r, v, inv, siic, rti, pc, exc_flush, exc_stall, exc_redirect,
             exc_target, epc, exc_cause, in_handler, err);
  endtask

  task automatic idle_n(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 16'h0);
  endtask

  initial begin
    rst = 1'b1; id_valid = 0; id_invalidOp = 0; id_siic = 0; id_rti = 0;
    id_pc = 16'h0; id_pc_inc = 16'h0;
    #1;
    step(0, 0, 0, 0, 1, 16'h0);
    chk_en = 1;
    step(0, 0, 0, 0, 1, 16'h0);
    idle_n(2);

    // Illegal opcode at 0x0040, drain, handler entry, then RTI back.
    step(1, 1, 0, 0, 0, 16'h0040);
    chk("epc_0040", epc, 16'h0040);
    chk("cause_ill", exc_cause, 2'b01);
    idle_n(6);
    step(1, 0, 0, 1, 0, 16'h0010);
    idle_n(2);

    // SIIC saves PC+2; RTI returns there.
    step(1, 0, 1, 0, 0, 16'h0100);
    chk("epc_0102", epc, 16'h0102);
    idle_n(6);
    step(1, 0, 0, 1, 0, 16'h0012);
    chk("ret_target", exc_target, 16'h0102);
    idle_n(2);

    // Stray RTI in IDLE is an exception.
    step(1, 0, 0, 1, 0, 16'h0020);
    chk("cause_rti", exc_cause, 2'b11);
    idle_n(6);
    step(1, 0, 0, 1, 0, 16'h0014);
    idle_n(2);

    // Double fault, then reset recovery.
    step(1, 1, 0, 0, 0, 16'h0200);
    idle_n(5);
    step(1, 1, 0, 0, 0, 16'h0004);
    idle_n(3);
    chk("err_sticky", err, 1'b1);
    step(0, 0, 0, 0, 1, 16'h0);
    idle_n(2);

    // Flags without valid are ignored; reset mid-drain; reset with trigger.
    step(0, 1, 1, 1, 0, 16'h0300);
    idle_n(1);
    step(1, 0, 1, 0, 0, 16'h0400);
    idle_n(1);
    step(0, 0, 0, 0, 1, 16'h0);
    idle_n(5);
    step(1, 1, 0, 0, 1, 16'h0500);
    idle_n(2);

    // Trigger in the first IDLE cycle after RETURN.
    step(1, 1, 1, 1, 0, 16'h0600);
    idle_n(5);
    step(1, 0, 0, 1, 0, 16'h0006);
    idle_n(1);
    step(1, 0, 1, 0, 0, 16'h0700);
    idle_n(6);

    // Random decode traffic.
    for (int i = 0; i < 800; i++) begin
      int          sel;
      bit          v, inv, siic, rti, r;
      logic [15:0] rpc;
      sel = $urandom_range(0, 99);
      v   = ($urandom_range(0, 3) != 0);
      r   = ($urandom_range(0, 99) < 2);
      inv = (sel < 3) || (sel >= 3 && sel < 7);
      siic = (sel < 3) || (sel >= 7 && sel < 12);
      rti = (sel < 3) || (sel >= 12 && sel < 24);
      rpc = 16'($urandom) & 16'hFFFE;
      step(v, inv, siic, rti, r, rpc);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
